btfa_serial_ctrl: RTL

- Trit-serial balanced-ternary add/subtract engine. It shares one `btfa` full-adder cell across all WIDTH trit positions, one position per cycle, LSB first.
- Operands arrive on a valid/ready request channel. The result leaves on a valid/ready response channel.
- Serves as the area-minimal adder option for the ternary datapath, for example in ALU multi-cycle paths and address-offset units.

---
 rtl/ternary_pkg.sv | 38 +++
 rtl/btfa.sv | 29 ++
 rtl/btfa_serial_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ternary_pkg.sv
// Balanced-ternary trit encoding and helpers shared by the ternary datapath.
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t T_ZERO    = 2'b00;
  localparam trit_t T_POS_ONE = 2'b01;
  localparam trit_t T_NEG_ONE = 2'b10;
  localparam trit_t T_INVALID = 2'b11;

  typedef enum logic [1:0] {
    BSC_IDLE = 2'd0,
    BSC_RUN  = 2'd1,
    BSC_DONE = 2'd2
  } bsc_state_t;

  // T_INVALID maps to 0; callers flag it separately.
  function automatic int trit_to_int(trit_t t);
    case (t)
      T_POS_ONE: return 1;
      T_NEG_ONE: return -1;
      default:   return 0;
    endcase
  endfunction

  function automatic trit_t trit_neg(trit_t t);
    case (t)
      T_POS_ONE: return T_NEG_ONE;
      T_NEG_ONE: return T_POS_ONE;
      default:   return t;
    endcase
  endfunction

  function automatic logic trit_is_valid(trit_t t);
    return t != T_INVALID;
  endfunction

endpackage

// File: rtl/btfa.sv
// Balanced-ternary full adder: a + b + cin = sum + 3*cout, purely combinational.
module btfa
  import ternary_pkg::*;
(
  input  trit_t a,
  input  trit_t b,
  input  trit_t cin,
  output trit_t sum,
  output trit_t cout
);

  int w_total;

  always_comb begin
    w_total = trit_to_int(a) + trit_to_int(b) + trit_to_int(cin);
    sum     = T_ZERO;
    cout    = T_ZERO;
    case (w_total)
      3:  begin sum = T_ZERO;    cout = T_POS_ONE; end
      2:  begin sum = T_NEG_ONE; cout = T_POS_ONE; end
      1:        sum = T_POS_ONE;
      -1:       sum = T_NEG_ONE;
      -2: begin sum = T_POS_ONE; cout = T_NEG_ONE; end
      -3: begin sum = T_ZERO;    cout = T_NEG_ONE; end
      default: ;
    endcase
  end

endmodule

// File: rtl/btfa_serial_ctrl.sv
// Trit-serial balanced-ternary add/subtract: one shared btfa cell walks the
// operand LSB first, one trit per cycle, between valid/ready channels.
module btfa_serial_ctrl
  import ternary_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_a,
  input  logic [2*WIDTH-1:0] in_b,
  input  logic [1:0]         in_cin,
  input  logic               in_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_sum,
  output logic [1:0]         out_cout,
  output logic               out_err,
  output logic               busy
);

  bsc_state_t         r_state;
  logic [CNT_W-1:0]   r_idx;
  trit_t              r_carry;
  logic [2*WIDTH-1:0] r_a;
  logic [2*WIDTH-1:0] r_b;
  logic [2*WIDTH-1:0] r_sum;
  logic               r_err;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [2*WIDTH-1:0] w_b_lat;
  logic               w_in_err;
  trit_t              w_a_t;
  trit_t              w_b_t;
  trit_t              w_sum;
  trit_t              w_cout;

  // Subtraction is folded into the latch so the serial loop only ever adds.
  always_comb begin
    w_b_lat  = '0;
    w_in_err = !trit_is_valid(in_cin);
    for (int i = 0; i < WIDTH; i++) begin
      w_b_lat[2*i +: 2] = in_sub ? trit_neg(in_b[2*i +: 2]) : in_b[2*i +: 2];
      w_in_err = w_in_err | !trit_is_valid(in_a[2*i +: 2])
                          | !trit_is_valid(in_b[2*i +: 2]);
    end
  end

  assign w_a_t = r_a[{r_idx, 1'b0} +: 2];
  assign w_b_t = r_b[{r_idx, 1'b0} +: 2];

  btfa u_btfa (
    .a    (w_a_t),
    .b    (w_b_t),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= BSC_IDLE;
      r_idx       <= '0;
      r_carry     <= T_ZERO;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        BSC_IDLE: begin
          if (in_valid) begin
            r_a        <= in_a;
            r_b        <= w_b_lat;
            r_carry    <= in_cin;
            r_idx      <= '0;
            r_err      <= w_in_err;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= BSC_RUN;
          end
        end
        BSC_RUN: begin
          r_sum[{r_idx, 1'b0} +: 2] <= w_sum;
          r_carry <= w_cout;
          if (r_idx == CNT_W'(WIDTH - 1)) begin
            r_out_valid <= 1'b1;
            r_state     <= BSC_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        BSC_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= BSC_IDLE;
          end
        end
        default: r_state <= BSC_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_sum   = r_sum;
  assign out_cout  = r_carry;
  assign out_err   = r_err;

endmodule
